// File: rtl/vrrm_freelist.sv
// Vector register remapper with a bitmap free-list and true renaming.
// Ports: decode in (valid/ready), exe + mem out channels, release in, status.
module vrrm_freelist #(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES = 8,
  parameter int MAX_GROUP = 8,
  localparam int RB = $clog2(VECTOR_REGISTERS),
  localparam int VLW = $clog2(VECTOR_REGISTERS * VECTOR_LANES) + 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [RB-1:0] in_dst_i,
  input  logic [RB-1:0] in_src1_i,
  input  logic [RB-1:0] in_src2_i,
  input  logic [VLW-1:0] in_maxvl_i,
  input  logic          in_reconfig_i,
  input  logic          in_is_mem_i,
  input  logic          in_is_store_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [RB-1:0] out_dst_o,
  output logic [RB-1:0] out_src1_o,
  output logic [RB-1:0] out_src2_o,
  output logic [RB-1:0] out_old_dst_o,
  output logic          out_old_valid_o,
  output logic [RB:0]   out_hop_o,
  output logic          out_lock_o,
  input  logic          rel_valid_i,
  input  logic [RB-1:0] rel_base_i,
  output logic [RB:0]   free_count_o,
  output logic          err_o,
  output logic          is_idle_o
);

  localparam int LW = $clog2(VECTOR_LANES);
  localparam int GW = $clog2(MAX_GROUP);
  localparam int NR = VECTOR_REGISTERS;

  logic [NR-1:0] free_q;
  logic [NR-1:0] map_q;
  logic [RB-1:0] rat_q [NR];
  logic [RB:0]   size_q [NR];
  logic          err_q;

  logic          exe_q, mem_q;
  logic [RB-1:0] dst_q, s1_q, s2_q, old_q;
  logic          oldv_q, lock_q;
  logic [RB:0]   hop_q;

  logic [VLW-1:0] raw;
  logic [RB:0]    hop;
  logic           found;
  logic           fit;
  logic [RB-1:0]  base;
  logic [NR-1:0]  alloc_mask;
  logic [NR-1:0]  rel_mask;
  logic [RB:0]    rel_size;
  logic           rel_ok;
  logic           skip, buf_free, acc;
  logic           do_rcfg, do_alloc;
  logic [RB-1:0]  s1_phys, s2_phys;

  assign raw = in_maxvl_i >> LW;

  // smallest power of two covering raw, capped at MAX_GROUP
  always_comb begin
    hop = (RB+1)'(MAX_GROUP);
    for (int i = GW; i >= 0; i--)
      if (raw <= VLW'(1 << i))
        hop = (RB+1)'(1 << i);
  end

  // descending scan so the lowest aligned fitting base wins
  always_comb begin
    found = 1'b0;
    base = '0;
    fit = 1'b0;
    for (int b = NR - 1; b >= 0; b--) begin
      fit = ((RB+1)'(b) & (hop - (RB+1)'(1))) == '0;
      for (int k = 0; k < MAX_GROUP; k++)
        if ((RB+1)'(k) < hop) begin
          if (b + k >= NR)
            fit = 1'b0;
          else if (!free_q[RB'(b + k)])
            fit = 1'b0;
        end
      if (fit) begin
        found = 1'b1;
        base = RB'(b);
      end
    end
  end

  assign rel_size = size_q[rel_base_i];
  assign rel_ok = rel_valid_i
    && (rel_size != '0)
    && !free_q[rel_base_i];

  always_comb begin
    alloc_mask = '0;
    rel_mask = '0;
    for (int i = 0; i < NR; i++) begin
      alloc_mask[i] = ((RB+1)'(i) >= {1'b0, base})
        && ((RB+1)'(i) < {1'b0, base} + hop);
      rel_mask[i] = ((RB+1)'(i) >= {1'b0, rel_base_i})
        && ((RB+1)'(i) < {1'b0, rel_base_i} + rel_size);
    end
  end

  assign skip = in_is_store_i | in_reconfig_i;
  assign buf_free = (!exe_q || out_ready_i)
    && (!mem_q || m_ready_i);
  assign in_ready_o = buf_free && (skip || found);
  assign acc = in_valid_i && in_ready_o;
  assign do_rcfg = acc && in_reconfig_i;
  assign do_alloc = acc && !skip;

  assign s1_phys = map_q[in_src1_i] ? rat_q[in_src1_i] : in_src1_i;
  assign s2_phys = map_q[in_src2_i] ? rat_q[in_src2_i] : in_src2_i;

  // allocation sees the pre-release bitmap; masks never overlap
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      free_q <= '1;
      map_q <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < NR; i++) begin
        rat_q[i] <= '0;
        size_q[i] <= '0;
      end
    end else if (do_rcfg) begin
      free_q <= '1;
      map_q <= '0;
      for (int i = 0; i < NR; i++)
        size_q[i] <= '0;
    end else begin
      free_q <= (free_q | (rel_ok ? rel_mask : '0))
        & ~(do_alloc ? alloc_mask : '0);
      if (rel_ok)
        size_q[rel_base_i] <= '0;
      if (do_alloc) begin
        size_q[base] <= hop;
        rat_q[in_dst_i] <= base;
        map_q[in_dst_i] <= 1'b1;
      end
      if (rel_valid_i && !rel_ok)
        err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      exe_q <= 1'b0;
      mem_q <= 1'b0;
      dst_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      old_q <= '0;
      oldv_q <= 1'b0;
      hop_q <= '0;
      lock_q <= 1'b0;
    end else if (acc) begin
      exe_q <= 1'b1;
      mem_q <= in_is_mem_i;
      dst_q <= skip ? in_dst_i : base;
      s1_q <= s1_phys;
      s2_q <= s2_phys;
      old_q <= rat_q[in_dst_i];
      oldv_q <= !skip && map_q[in_dst_i];
      hop_q <= hop;
      lock_q <= in_is_mem_i && !in_reconfig_i;
    end else begin
      if (out_ready_i)
        exe_q <= 1'b0;
      if (m_ready_i)
        mem_q <= 1'b0;
    end
  end

  always_comb begin
    free_count_o = '0;
    for (int i = 0; i < NR; i++)
      free_count_o = free_count_o + (RB+1)'(free_q[i]);
  end

  assign out_valid_o = exe_q;
  assign m_valid_o = mem_q;
  assign out_dst_o = dst_q;
  assign out_src1_o = s1_q;
  assign out_src2_o = s2_q;
  assign out_old_dst_o = old_q;
  assign out_old_valid_o = oldv_q;
  assign out_hop_o = hop_q;
  assign out_lock_o = lock_q;
  assign err_o = err_q;
  assign is_idle_o = !in_valid_i && !exe_q && !mem_q;

endmodule

// File: tb/tb_vrrm_freelist.sv
// Bench for vrrm_freelist: vector table, corner sequences,
// then random traffic against a behavioural free-list model.
module tb_vrrm_freelist;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid, in_ready;
  logic [4:0] in_dst, in_src1, in_src2;
  logic [8:0] in_maxvl;
  logic in_reconfig, in_is_mem, in_is_store;
  logic out_valid, out_ready, m_valid, m_ready;
  logic [4:0] out_dst, out_src1, out_src2, out_old_dst;
  logic out_old_valid;
  logic [5:0] out_hop;
  logic out_lock;
  logic rel_valid;
  logic [4:0] rel_base;
  logic [5:0] free_count;
  logic err, is_idle;

  int pass_n = 0;
  int total_n = 0;

  vrrm_freelist dut (
    .clk_i(clk), .rstn_i(rstn),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_dst_i(in_dst), .in_src1_i(in_src1), .in_src2_i(in_src2),
    .in_maxvl_i(in_maxvl), .in_reconfig_i(in_reconfig),
    .in_is_mem_i(in_is_mem), .in_is_store_i(in_is_store),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .m_valid_o(m_valid), .m_ready_i(m_ready),
    .out_dst_o(out_dst), .out_src1_o(out_src1),
    .out_src2_o(out_src2), .out_old_dst_o(out_old_dst),
    .out_old_valid_o(out_old_valid), .out_hop_o(out_hop),
    .out_lock_o(out_lock), .rel_valid_i(rel_valid),
    .rel_base_i(rel_base), .free_count_o(free_count),
    .err_o(err), .is_idle_o(is_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dst, s1, s2, mvl, st;
    int e_dst, e_s1, e_s2, e_old, e_oldv, e_hop, e_free;
  } vec_t;
  vec_t tbl [8];

  // behavioural model state
  bit mfree [32];
  int mrat [32];
  int msize [32];
  bit merr, pe, pm;
  int e_dst, e_s1, e_s2, e_old, e_oldv, e_hop, e_lock;

  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act !== exp)
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    else
      pass_n++;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_dst = '0;
    in_src1 = '0;
    in_src2 = '0;
    in_maxvl = '0;
    in_reconfig = 1'b0;
    in_is_mem = 1'b0;
    in_is_store = 1'b0;
    rel_valid = 1'b0;
    rel_base = '0;
  endtask

  task automatic set_in(input int dst, input int s1, input int s2,
                        input int mvl, input int rc, input int mem,
                        input int st);
    in_dst = 5'(dst);
    in_src1 = 5'(s1);
    in_src2 = 5'(s2);
    in_maxvl = 9'(mvl);
    in_reconfig = 1'(rc);
    in_is_mem = 1'(mem);
    in_is_store = 1'(st);
    in_valid = 1'b1;
  endtask

  task automatic issue(input int dst, input int s1, input int s2,
                       input int mvl, input int rc, input int mem,
                       input int st);
    int n;
    n = 0;
    set_in(dst, s1, s2, mvl, rc, mem, st);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50)
      chk("issue_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rstn = 1'b0;
    #2;
    chk("rst_free", int'(free_count), 32);
    chk("rst_oval", int'(out_valid), 0);
    chk("rst_mval", int'(m_valid), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_idle", int'(is_idle), 1);
    out_ready = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic int mhop(input int mvl);
    int raw, h;
    raw = mvl / 8;
    h = 1;
    while (h < raw) h = h * 2;
    if (h > 8) h = 8;
    return h;
  endfunction

  function automatic int mfind(input int h);
    bit ok;
    for (int b = 0; b + h <= 32; b += h) begin
      ok = 1;
      for (int k = 0; k < h; k++)
        if (!mfree[b + k]) ok = 0;
      if (ok) return b;
    end
    return -1;
  endfunction

  function automatic int mcount();
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(mfree[i]);
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      mfree[i] = 1;
      mrat[i] = -1;
      msize[i] = 0;
    end
  endtask

  initial begin
    int h, b, rb, pick, st, s1v, s2v, dv;
    bit bf, er, acc, rc;

    tbl[0] = '{3, 3, 0, 32, 0, 0, 3, 0, 0, 0, 4, 28};
    tbl[1] = '{3, 3, 1, 32, 0, 4, 0, 1, 0, 1, 4, 24};
    tbl[2] = '{5, 3, 5, 24, 0, 8, 4, 5, 0, 0, 4, 20};
    tbl[3] = '{6, 5, 2, 128, 0, 16, 8, 2, 0, 0, 8, 12};
    tbl[4] = '{9, 6, 0, 4, 0, 12, 16, 0, 0, 0, 1, 11};
    tbl[5] = '{10, 9, 10, 0, 0, 13, 12, 10, 0, 0, 1, 10};
    tbl[6] = '{20, 3, 5, 32, 1, 20, 4, 8, 0, 0, 4, 10};
    tbl[7] = '{3, 10, 9, 9, 0, 14, 13, 12, 4, 1, 1, 9};

    idle_in();
    out_ready = 1'b1;
    m_ready = 1'b1;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].dst, tbl[i].s1, tbl[i].s2, tbl[i].mvl,
            0, 0, tbl[i].st);
      chk($sformatf("t%0d_val", i), int'(out_valid), 1);
      chk($sformatf("t%0d_dst", i), int'(out_dst), tbl[i].e_dst);
      chk($sformatf("t%0d_s1", i), int'(out_src1), tbl[i].e_s1);
      chk($sformatf("t%0d_s2", i), int'(out_src2), tbl[i].e_s2);
      chk($sformatf("t%0d_oldv", i), int'(out_old_valid),
          tbl[i].e_oldv);
      if (tbl[i].e_oldv != 0)
        chk($sformatf("t%0d_old", i), int'(out_old_dst),
            tbl[i].e_old);
      chk($sformatf("t%0d_hop", i), int'(out_hop), tbl[i].e_hop);
      chk($sformatf("t%0d_free", i), int'(free_count),
          tbl[i].e_free);
    end

    // fill the file, stall, release base 8, accept after
    do_reset();
    for (int i = 0; i < 8; i++)
      issue(i, 0, 0, 32, 0, 0, 0);
    chk("full_free", int'(free_count), 0);
    set_in(1, 0, 0, 32, 0, 0, 0);
    @(negedge clk);
    chk("full_stall", int'(in_ready), 0);
    rel_valid = 1'b1;
    rel_base = 5'd8;
    #1;
    chk("no_bypass", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    @(negedge clk);
    chk("rel_ready", int'(in_ready), 1);
    chk("rel_free", int'(free_count), 4);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("reuse_dst", int'(out_dst), 8);
    chk("reuse_oldv", int'(out_old_valid), 1);
    chk("reuse_old", int'(out_old_dst), 4);
    chk("reuse_free", int'(free_count), 0);

    // reconfigure beats a bad release; then error + overlap cases
    rel_valid = 1'b1;
    rel_base = 5'd5;
    issue(2, 7, 0, 32, 1, 0, 0);
    rel_valid = 1'b0;
    chk("rcfg_free", int'(free_count), 32);
    chk("rcfg_dst", int'(out_dst), 2);
    chk("rcfg_noerr", int'(err), 0);
    rel_valid = 1'b1;
    rel_base = 5'd5;
    @(posedge clk);
    #1;
    rel_valid = 1'b0;
    chk("bad_rel_err", int'(err), 1);
    chk("bad_rel_free", int'(free_count), 32);
    issue(7, 7, 0, 32, 0, 0, 0);
    chk("post_rcfg_dst", int'(out_dst), 0);
    chk("post_rcfg_src", int'(out_src1), 7);
    chk("post_rcfg_free", int'(free_count), 28);
    rel_valid = 1'b1;
    rel_base = 5'd0;
    issue(8, 0, 0, 32, 0, 0, 0);
    rel_valid = 1'b0;
    chk("relalloc_dst", int'(out_dst), 4);
    chk("relalloc_free", int'(free_count), 28);
    chk("err_sticky", int'(err), 1);

    // memory channel held while exe completes early
    do_reset();
    m_ready = 1'b0;
    issue(4, 0, 0, 32, 0, 1, 0);
    chk("ld_oval", int'(out_valid), 1);
    chk("ld_mval", int'(m_valid), 1);
    chk("ld_lock", int'(out_lock), 1);
    set_in(5, 0, 0, 32, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      m_ready = 1'(k == 3);
      @(negedge clk);
      chk($sformatf("ld_m%0d", k), int'(m_valid), 1);
      chk($sformatf("ld_e%0d", k), int'(out_valid), int'(k == 0));
      chk($sformatf("ld_r%0d", k), int'(in_ready), int'(k == 3));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("ld_next_dst", int'(out_dst), 4);
    chk("ld_next_mval", int'(m_valid), 0);
    chk("ld_next_lock", int'(out_lock), 0);

    // reset with a half-finished entry in flight
    m_ready = 1'b0;
    issue(6, 0, 0, 32, 0, 1, 0);
    do_reset();

    // random traffic against the model
    model_clear();
    merr = 0;
    pe = 0;
    pm = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      in_valid = 1'($urandom_range(0, 99) < 70);
      in_dst = 5'($urandom_range(0, 31));
      in_src1 = 5'($urandom_range(0, 31));
      in_src2 = 5'($urandom_range(0, 31));
      in_maxvl = 9'($urandom_range(0, 80));
      in_reconfig = 1'($urandom_range(0, 99) < 3);
      in_is_store = 1'($urandom_range(0, 99) < 15);
      in_is_mem = 1'($urandom_range(0, 99) < 35);
      out_ready = 1'($urandom_range(0, 99) < 75);
      m_ready = 1'($urandom_range(0, 99) < 75);
      rel_valid = 1'($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 99) < 95) begin
        st = int'($urandom_range(0, 31));
        pick = -1;
        for (int j = 0; j < 32; j++)
          if (pick < 0 && msize[(st + j) % 32] != 0)
            pick = (st + j) % 32;
        rel_base = 5'(pick < 0 ? st : pick);
      end else begin
        rel_base = 5'($urandom_range(0, 31));
      end

      @(negedge clk);
      h = mhop(int'(in_maxvl));
      b = mfind(h);
      bf = (!pe || out_ready) && (!pm || m_ready);
      er = bf && (in_is_store || in_reconfig || b >= 0);
      chk("r_ready", int'(in_ready), int'(er));
      chk("r_oval", int'(out_valid), int'(pe));
      chk("r_mval", int'(m_valid), int'(pm));
      chk("r_free", int'(free_count), mcount());
      chk("r_err", int'(err), int'(merr));
      if (pe || pm) begin
        chk("r_dst", int'(out_dst), e_dst);
        chk("r_s1", int'(out_src1), e_s1);
        chk("r_s2", int'(out_src2), e_s2);
        chk("r_hop", int'(out_hop), e_hop);
        chk("r_lock", int'(out_lock), e_lock);
        chk("r_oldv", int'(out_old_valid), e_oldv);
        if (e_oldv != 0)
          chk("r_old", int'(out_old_dst), e_old);
      end

      acc = in_valid && er;
      if (pe && out_ready) pe = 0;
      if (pm && m_ready) pm = 0;
      rc = acc && in_reconfig;
      if (rel_valid && !rc) begin
        rb = int'(rel_base);
        if (msize[rb] != 0 && !mfree[rb]) begin
          for (int k = 0; k < msize[rb]; k++)
            mfree[rb + k] = 1;
          msize[rb] = 0;
        end else begin
          merr = 1;
        end
      end
      if (acc) begin
        dv = int'(in_dst);
        s1v = int'(in_src1);
        s2v = int'(in_src2);
        e_s1 = mrat[s1v] >= 0 ? mrat[s1v] : s1v;
        e_s2 = mrat[s2v] >= 0 ? mrat[s2v] : s2v;
        e_hop = h;
        e_lock = int'(in_is_mem && !in_reconfig);
        pe = 1;
        pm = in_is_mem;
        e_oldv = 0;
        e_dst = dv;
        if (rc) begin
          model_clear();
        end else if (!in_is_store) begin
          e_oldv = int'(mrat[dv] >= 0);
          e_old = mrat[dv];
          mrat[dv] = b;
          for (int k = 0; k < h; k++)
            mfree[b + k] = 0;
          msize[b] = h;
          e_dst = b;
        end
      end
      @(posedge clk);
      #1;
    end

    idle_in();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
